// File: rtl/seq_if.sv
// Bus between the instruction sequencer and its decoder/memory neighbours.
interface seq_if;
    logic [31:0] instr_in;
    logic        ir_we;
    logic        T_rst;
    logic        hlt;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] ir;
    logic [2:0]  T;
    logic [2:0]  instr_type;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        stall;
    logic        halted;
    logic        seq_err;
    logic [31:0] instret;

    modport master (
        output instr_in, ir_we, T_rst, hlt, mem_req, mem_ready,
        input  ir, T, instr_type, opcode, funct3, rd, rs1, rs2, stall, halted, seq_err, instret
    );

    modport slave (
        input  instr_in, ir_we, T_rst, hlt, mem_req, mem_ready,
        output ir, T, instr_type, opcode, funct3, rd, rs1, rs2, stall, halted, seq_err, instret
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction register, T-state counter, type classifier, halt latch, watchdog and retire counter.
// Optional memory wait-states are enabled by defining SEQ_MEM_WAIT_EN.
module instr_sequencer #(
    parameter logic [2:0]  MAX_T    = 3'd2,
    parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
    input logic  clk,
    input logic  rst_n,
    seq_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned TW   = 3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic [TW-1:0]     t_q, t_d;
    logic              err_q, err_d;
    logic              stall_c;
    logic [2:0]        type_c;

`ifdef SEQ_MEM_WAIT_EN
    assign stall_c = bus.mem_req & ~bus.mem_ready & (state_q == ST_RUN);
`else
    logic unused_mem;
    assign unused_mem = bus.mem_req ^ bus.mem_ready;
    assign stall_c    = 1'b0;
`endif

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ir_q      <= RESET_IR;
            instret_q <= '0;
            t_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            t_q       <= t_d;
            err_q     <= err_d;
        end
    end

    // Sequencing: hlt beats T_rst beats watchdog beats normal advance
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        t_d       = t_q;
        err_d     = err_q;
        if (state_q == ST_RUN && !stall_c) begin
            if (bus.ir_we) ir_d = bus.instr_in;
            if (bus.hlt) begin
                state_d = ST_HALT;
                t_d     = '0;
            end else if (bus.T_rst) begin
                t_d       = '0;
                instret_d = instret_q + XLEN'(1);
            end else if (t_q == MAX_T) begin
                t_d   = '0;
                err_d = 1'b1;
            end else begin
                t_d = t_q + TW'(1);
            end
        end
    end

    // Instruction type classification
    always_comb begin
        type_c = 3'd0;
        case (ir_q[6:0])
            OP_R:                        type_c = 3'd1;
            OP_I_ALU, OP_LOAD, OP_JALR:  type_c = 3'd2;
            OP_STORE:                    type_c = 3'd3;
            OP_BRANCH:                   type_c = 3'd4;
            OP_LUI, OP_AUIPC:            type_c = 3'd5;
            OP_JAL:                      type_c = 3'd6;
            OP_FENCE, OP_SYSTEM:         type_c = 3'd7;
            default:                     type_c = 3'd0;
        endcase
    end

    assign bus.ir         = ir_q;
    assign bus.T          = t_q;
    assign bus.instr_type = type_c;
    assign bus.opcode     = ir_q[6:0];
    assign bus.funct3     = ir_q[14:12];
    assign bus.rd         = ir_q[11:7];
    assign bus.rs1        = ir_q[19:15];
    assign bus.rs2        = ir_q[24:20];
    assign bus.stall      = stall_c;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.seq_err    = err_q;
    assign bus.instret    = instret_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized traffic vs. a reference model.
module tb_instr_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    seq_if bus();

    instr_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_ir;
    int          m_t;
    bit          m_halted;
    bit          m_err;
    longint      m_instret;
    logic [31:0] saved;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_type(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h33) return 3'd1;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67) return 3'd2;
        if (op == 7'h23) return 3'd3;
        if (op == 7'h63) return 3'd4;
        if (op == 7'h37 || op == 7'h17) return 3'd5;
        if (op == 7'h6f) return 3'd6;
        if (op == 7'h0f || op == 7'h73) return 3'd7;
        return 3'd0;
    endfunction

    function automatic bit ref_stall();
`ifdef SEQ_MEM_WAIT_EN
        return bus.mem_req && !bus.mem_ready && !m_halted;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_ir = 32'h0; m_t = 0; m_halted = 0; m_err = 0; m_instret = 0;
    endtask

    // One clock edge of the architectural rules
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (!m_halted && !ref_stall()) begin
            if (bus.ir_we) m_ir = bus.instr_in;
            if (bus.hlt) begin m_halted = 1; m_t = 0; end
            else if (bus.T_rst) begin m_t = 0; m_instret = (m_instret + 1) % (64'd1 << 32); end
            else if (m_t == 2) begin m_t = 0; m_err = 1; end
            else m_t = m_t + 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ir"}, bus.ir, m_ir);
        check({tag, ".T"}, 32'(bus.T), 32'(m_t));
        check({tag, ".type"}, 32'(bus.instr_type), 32'(ref_type(m_ir)));
        check({tag, ".opcode"}, 32'(bus.opcode), 32'(m_ir[6:0]));
        check({tag, ".funct3"}, 32'(bus.funct3), 32'(m_ir[14:12]));
        check({tag, ".rd"}, 32'(bus.rd), 32'(m_ir[11:7]));
        check({tag, ".rs1"}, 32'(bus.rs1), 32'(m_ir[19:15]));
        check({tag, ".rs2"}, 32'(bus.rs2), 32'(m_ir[24:20]));
        check({tag, ".stall"}, 32'(bus.stall), 32'(ref_stall()));
        check({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
        check({tag, ".seq_err"}, 32'(bus.seq_err), 32'(m_err));
        check({tag, ".instret"}, bus.instret, 32'(m_instret));
    endtask

    // Drive one cycle's inputs (called just after a rising edge), check at negedge, step at posedge
    task automatic cycle(input string tag, input bit we, input logic [31:0] instr, input bit trst,
                         input bit h, input bit mreq, input bit mrdy);
        bus.ir_we = we; bus.instr_in = instr; bus.T_rst = trst; bus.hlt = h;
        bus.mem_req = mreq; bus.mem_ready = mrdy;
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_all("reset");
        rst_n = 1'b1;
    endtask

    logic [6:0] op_tab [12];
    initial begin
        op_tab[0] = 7'h33; op_tab[1] = 7'h13; op_tab[2] = 7'h03; op_tab[3] = 7'h67;
        op_tab[4] = 7'h23; op_tab[5] = 7'h63; op_tab[6] = 7'h37; op_tab[7] = 7'h17;
        op_tab[8] = 7'h6f; op_tab[9] = 7'h0f; op_tab[10] = 7'h73; op_tab[11] = 7'h00;
    end

    initial begin
        int halt_cnt;
        logic [31:0] w;
        logic [6:0] op;
        rst_n = 1'b1;
        bus.ir_we = 0; bus.instr_in = 0; bus.T_rst = 0; bus.hlt = 0; bus.mem_req = 0; bus.mem_ready = 1;
        #2;
        do_reset();

        // 1: addi, retire at T=1
        cycle("t1a", 1, 32'h00500093, 0, 0, 0, 1);
        check("t1.T1", 32'(bus.T), 32'd1);
        check("t1.type", 32'(bus.instr_type), 32'd2);
        check("t1.rd", 32'(bus.rd), 32'd1);
        check("t1.rs1", 32'(bus.rs1), 32'd0);
        cycle("t1b", 0, 32'h0, 1, 0, 0, 1);
        check("t1.T0", 32'(bus.T), 32'd0);
        check("t1.instret", bus.instret, 32'd1);

        // 2: sw, retire at T=2
        cycle("t2a", 1, 32'h0000A023, 0, 0, 0, 1);
        check("t2.type", 32'(bus.instr_type), 32'd3);
        cycle("t2b", 0, 32'h0, 0, 0, 0, 1);
        check("t2.T2", 32'(bus.T), 32'd2);
        cycle("t2c", 0, 32'h0, 1, 0, 0, 1);
        check("t2.T0", 32'(bus.T), 32'd0);
        check("t2.instret", bus.instret, 32'd2);
        check("t2.seq_err", 32'(bus.seq_err), 32'd0);

`ifdef SEQ_MEM_WAIT_EN
        // 3: memory wait-states at T=0
        saved = bus.ir;
        for (int i = 0; i < 3; i++) begin
            cycle("t3w", 1, 32'h00208033, 0, 0, 1, 0);
            check("t3.T", 32'(bus.T), 32'd0);
            check("t3.ir", bus.ir, saved);
        end
        cycle("t3r", 1, 32'h00208033, 0, 0, 1, 1);
        check("t3.ir_loaded", bus.ir, 32'h00208033);
        check("t3.T1", 32'(bus.T), 32'd1);
        cycle("t3e", 0, 32'h0, 1, 0, 0, 1);
`endif

        // 4: illegal word, hlt at T=1, then everything frozen
        saved = bus.instret;
        cycle("t4a", 1, 32'h00000000, 0, 0, 0, 1);
        check("t4.type", 32'(bus.instr_type), 32'd0);
        cycle("t4b", 0, 32'h0, 0, 1, 0, 1);
        check("t4.halted", 32'(bus.halted), 32'd1);
        check("t4.T", 32'(bus.T), 32'd0);
        check("t4.instret", bus.instret, saved);
        for (int i = 0; i < 4; i++) cycle("t4h", 1, 32'h00500093, i[0], 0, 1, 0);
        check("t4.ir_frozen", bus.ir, 32'h0);
        check("t4.instret_frozen", bus.instret, saved);
        check("t4.stall_forced0", 32'(bus.stall), 32'd0);
        do_reset();

        // 5: watchdog, sticky over a retire
        cycle("t5a", 1, 32'h00100073, 0, 0, 0, 1);
        cycle("t5b", 0, 32'h0, 0, 0, 0, 1);
        cycle("t5c", 0, 32'h0, 0, 0, 0, 1);
        check("t5.T0", 32'(bus.T), 32'd0);
        check("t5.seq_err", 32'(bus.seq_err), 32'd1);
        check("t5.no_retire", bus.instret, 32'd0);
        cycle("t5d", 0, 32'h0, 1, 0, 0, 1);
        check("t5.sticky", 32'(bus.seq_err), 32'd1);
        check("t5.retire", bus.instret, 32'd1);

        // 6: async reset mid-T=1 with instret=5
        do_reset();
        for (int i = 0; i < 5; i++) cycle("t6r", 1, 32'h00000033, 1, 0, 0, 1);
        cycle("t6a", 1, 32'h00500093, 0, 0, 0, 1);
        check("t6.pre_instret", bus.instret, 32'd5);
        check("t6.pre_T", 32'(bus.T), 32'd1);
        #2; rst_n = 1'b0; model_reset(); #1;
        check("t6.instret", bus.instret, 32'd0);
        check("t6.T", 32'(bus.T), 32'd0);
        check("t6.ir", bus.ir, 32'd0);
        check_all("t6");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Random traffic
        halt_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            if (($urandom_range(0, 299) == 0) || halt_cnt > 6) begin
                do_reset();
                halt_cnt = 0;
            end
            op = op_tab[$urandom_range(0, 11)];
            w = {$urandom(), op} >> 7;
            w = {w[24:0], op};
            if ($urandom_range(0, 15) == 0) w[1:0] = 2'(w[1:0] ^ 2'b01);
            cycle("rnd", 1'($urandom_range(0, 1)), w, ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            if (m_halted) halt_cnt++;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
